// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a transmit FIFO and a registered serial output.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_tx_param #(
  parameter int CLK_DIV    = 104,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state;
  logic [15:0]          bit_cnt;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_TX_PARITY_EN
  logic                 par;
`endif

  logic tick;
  logic last_stop;
  logic push;
  logic pop;
  logic shift;

  assign tick       = (bit_cnt == 16'(CLK_DIV - 1));
  assign last_stop  = (state == STOP) && tick && (stop_idx == 1'(STOP_BITS - 1));
  assign tx_ready   = (count != CW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign pop        = (count != '0) && ((state == IDLE) || last_stop);
  assign shift      = tick && ((state == START) || (state == DATA));
  assign fifo_count = count;

  // FIFO storage and the frame shift register carry data only, so they are not reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      shreg <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
      par   <= ^mem[rd_ptr];
`endif
    end else if (shift) begin
      shreg <= shreg >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Frame sequencer: bit_cnt restarts at every bit boundary and while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      bit_cnt <= ((state == IDLE) || tick) ? '0 : bit_cnt + 16'd1;
      case (state)
        IDLE: if (pop) begin
          state <= START;
          tx    <= 1'b0;
          busy  <= 1'b1;
        end
        START: if (tick) begin
          state   <= DATA;
          tx      <= shreg[0];
          bit_idx <= '0;
        end
        DATA: if (tick) begin
          if (bit_idx == 4'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state    <= PARITY;
            tx       <= par;
`else
            state    <= STOP;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
`endif
          end else begin
            tx      <= shreg[0];
            bit_idx <= bit_idx + 4'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (tick) begin
          state    <= STOP;
          tx       <= 1'b1;
          stop_idx <= 1'b0;
        end
`endif
        STOP: if (tick) begin
          if (last_stop) begin
            if (pop) begin
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            stop_idx <= stop_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: a timeline model predicts every frame start;
// a negedge monitor checks the serial line, busy and FIFO status cycle by cycle.
module tb_uart_tx_param;

  localparam int CLK_DIV    = 5;
  localparam int DATA_BITS  = 7;
  localparam int STOP_BITS  = 2;
  localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int NBITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
  localparam int FRAME = NBITS * CLK_DIV;

  logic                          clk;
  logic                          rst_n;
  logic [DATA_BITS-1:0]          tx_data;
  logic                          tx_valid;
  logic                          tx_ready;
  logic                          tx;
  logic                          busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  uart_tx_param #(
    .CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_BITS-1:0] word;
    int                   start;
  } frame_t;

  logic [DATA_BITS-1:0] fifo_q[$];
  frame_t               frame_q[$];
  int cyc     = 0;
  int free_at = 0;
  int n_chk   = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  // Line level of bit period b of a frame carrying word w
  function automatic int exp_level(input logic [DATA_BITS-1:0] w, input int b);
    if (b == 0) return 0;
    if (b <= DATA_BITS) return int'(w[b-1]);
    if (PAR_BITS == 1 && b == DATA_BITS + 1) return int'(^w);
    return 1;
  endfunction

  // Model: a word leaves the FIFO on any edge where the FIFO held it and the line is free;
  // the line is free again FRAME cycles after a frame starts.
  frame_t m_f;
  int     m_pre;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q.delete();
      frame_q.delete();
      free_at = 0;
    end else begin
      cyc++;
      m_pre = fifo_q.size();
      if (m_pre > 0 && cyc >= free_at) begin
        m_f.word  = fifo_q.pop_front();
        m_f.start = cyc;
        frame_q.push_back(m_f);
        free_at = cyc + FRAME;
      end
      if (tx_valid && m_pre != FIFO_DEPTH) fifo_q.push_back(tx_data);
    end
  end

  frame_t               cur;
  bit                   have_cur = 1'b0;
  logic [DATA_BITS-1:0] dec;
  int                   k;
  int                   exp_tx;
  int                   exp_busy;
  always @(negedge clk) begin
    if (!rst_n) begin
      have_cur = 1'b0;
    end else begin
      exp_tx   = 1;
      exp_busy = 0;
      if (!have_cur && frame_q.size() > 0 && frame_q[0].start == cyc) begin
        cur      = frame_q.pop_front();
        have_cur = 1'b1;
      end
      if (have_cur) begin
        k        = cyc - cur.start;
        exp_busy = 1;
        exp_tx   = exp_level(cur.word, k / CLK_DIV);
        if (k % CLK_DIV == CLK_DIV / 2 && k / CLK_DIV >= 1 && k / CLK_DIV <= DATA_BITS)
          dec[k / CLK_DIV - 1] = tx;
      end
      check("tx", int'(tx), exp_tx);
      check("busy", int'(busy), exp_busy);
      check("fifo_count", int'(fifo_count), fifo_q.size());
      check("tx_ready", int'(tx_ready), int'(fifo_q.size() != FIFO_DEPTH));
      if (have_cur && k == FRAME - 1) begin
        check("frame_word", int'(dec), int'(cur.word));
        have_cur = 1'b0;
      end
    end
  end

  function automatic bit idle_model();
    return fifo_q.size() == 0 && frame_q.size() == 0 && !have_cur;
  endfunction

  task automatic drain(input string name);
    int i;
    tx_valid = 1'b0;
    i = 0;
    while (!idle_model() && i < 20 * FRAME) begin
      @(posedge clk);
      i++;
    end
    #1 check(name, int'(idle_model()), 1);
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_count", int'(fifo_count), 0);
    check("reset_ready", int'(tx_ready), 1);

    // First word offered immediately after release must be taken on the first edge
    rst_n    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 7'h48;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    check("accept_count", int'(fifo_count), 1);
    check("accept_tx_high", int'(tx), 1);
    @(posedge clk);
    #1 check("start_low_next_cycle", int'(tx), 0);
    check("start_busy", int'(busy), 1);
    drain("drain_first");

    // Saturating, medium and sparse traffic; saturation keeps the FIFO full across frame ends
    for (int ph = 0; ph < 6; ph++) begin
      int pct;
      pct = (ph % 3 == 0) ? 100 : ((ph % 3 == 1) ? 50 : 3);
      repeat (300) begin
        @(posedge clk);
        #1;
        tx_valid = ($urandom_range(0, 99) < pct);
        tx_data  = DATA_BITS'($urandom);
      end
    end
    drain("drain_random");

    // Reset in the middle of a zero-data frame with three words queued
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      tx_valid = 1'b1;
      tx_data  = (i == 0) ? '0 : DATA_BITS'($urandom);
    end
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("pre_reset_queued", int'(fifo_count), 3);
    check("pre_reset_tx_low", int'(tx), 0);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_tx", int'(tx), 1);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_count", int'(fifo_count), 0);
    check("async_reset_ready", int'(tx_ready), 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3 * FRAME) @(posedge clk);
    #1 check("post_reset_idle_tx", int'(tx), 1);

    // Short random tail after the mid-frame reset
    repeat (400) begin
      @(posedge clk);
      #1;
      tx_valid = ($urandom_range(0, 99) < 20);
      tx_data  = DATA_BITS'($urandom);
    end
    drain("drain_tail");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter CLK_DIV, default 104: clk cycles per serial bit period, range 2..65535.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame, range 5..9.
REQ-003 Parameter STOP_BITS, default 1: stop bits per frame, 1 or 2.
REQ-004 Parameter FIFO_DEPTH, default 8: transmit FIFO entries, a power of 2, range 2..256.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 tx_data  input  DATA_BITS  word to transmit.
REQ-008 tx_valid  input  1  tx_data is valid this cycle.
REQ-009 tx_ready  output  1  FIFO can accept a word this cycle.
REQ-010 tx  output  1  serial line, registered, idle high.
REQ-011 busy  output  1  a frame is in progress on tx.
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH)+1  words held in the FIFO.

Function
REQ-013 A word SHALL be accepted on a rising edge where tx_valid=1 and tx_ready=1; tx_ready SHALL equal (fifo_count != FIFO_DEPTH).
REQ-014 When tx_valid=1 while tx_ready=0, the word SHALL be dropped and FIFO contents SHALL remain unchanged.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY (only when UART_TX_PARITY_EN is defined), and STOP.
REQ-016 In IDLE with fifo_count>0, the FSM SHALL pop the head word and enter START on the same edge, driving tx=0.
REQ-017 A word accepted into an empty FIFO while in IDLE SHALL produce tx=0 one cycle after the accepting edge.
REQ-018 Each bit SHALL hold tx for exactly CLK_DIV cycles, timed by a bit-period counter that resets at every bit boundary.
REQ-019 DATA SHALL send DATA_BITS bits LSB first; STOP SHALL drive tx=1 for STOP_BITS bit periods.
REQ-020 At the end of STOP with fifo_count>0, the FSM SHALL pop and start the next frame with no idle gap; otherwise it SHALL return to IDLE.
REQ-021 busy SHALL be 1 from the START entry edge through the last cycle of STOP.
REQ-022 A push and a pop on the same edge SHALL leave fifo_count unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 The popped word SHALL be held in a shift register, so FIFO writes during a frame cannot corrupt the frame in progress.

Reset
REQ-024 When rst_n=0: tx=1, busy=0, fifo_count=0, tx_ready=1, FSM in IDLE, pointers and bit counters 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately, return tx high asynchronously, and discard all FIFO contents.
REQ-026 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: an even-parity bit (XOR of data bits) SHALL be sent for one bit period between DATA and STOP.
REQ-028 Macro UART_TX_PARITY_EN undefined: the PARITY state and its logic SHALL be absent; a frame SHALL be 1+DATA_BITS+STOP_BITS bit periods.

Verification
REQ-029 Defaults, no parity; push 0x48 -> tx low 1 cycle later; bits 0,0,0,1,0,0,1,0 at 104 cycles each; stop bit high; busy=1 for exactly 1040 cycles.
REQ-030 UART_TX_PARITY_EN defined; push 0x07 -> parity bit 1; push 0x03 -> parity bit 0; frame length 1144 cycles each.
REQ-031 CLK_DIV=4; push 8 words back-to-back while tx is busy -> 9th push sees tx_ready=0 and is dropped; all 8 frames are contiguous with no idle gap, and fifo_count steps 8->0.
REQ-032 STOP_BITS=2, DATA_BITS=7; push 0x55 -> tx shows 7 alternating data bits starting at 1, then 2 high bit periods; frame length 10 x CLK_DIV.
REQ-033 Assert rst_n=0 mid-DATA with 3 words queued -> tx=1 and busy=0 immediately, fifo_count=0; no frame is transmitted after release.
REQ-034 FIFO full, and the frame ends on the same edge as a push -> the push is rejected (tx_ready=0) that cycle, the pop occurs, and fifo_count becomes FIFO_DEPTH-1.
